// File: rtl/multi_timer.sv
// Multi-channel programmable countdown timer with a shared free-running prescaler.
// Each channel supports one-shot/periodic modes, level pause, clear and restart-on-start.
module multi_timer #(
    parameter int CH       = 4,
    parameter int W        = 32,
    parameter int PRESCALE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [CH-1:0]   start,
    input  logic [CH-1:0]   stop,
    input  logic [CH-1:0]   clear,
    input  logic [CH-1:0]   mode,
    input  logic [CH*W-1:0] load_val,
    output logic [CH-1:0]   busy,
    output logic [CH-1:0]   done,
    output logic [CH-1:0]   expired,
    output logic [CH*W-1:0] cnt_out
);

    localparam int            PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    logic [PW-1:0] pre;
    logic          tick;

    assign tick = (pre == PRE_MAX);

    // Shared prescaler: never re-phased by start, so channel latency carries tick phase.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pre <= '0;
        end else if (tick) begin
            pre <= '0;
        end else begin
            pre <= pre + PW'(1);
        end
    end

    for (genvar i = 0; i < CH; i++) begin : g_ch
        state_t         state;
        logic [W-1:0]   cnt;
        logic [W-1:0]   reload;
        logic           mode_q;
        logic           done_q;
        logic [W-1:0]   ld;

        assign ld = load_val[i*W +: W];

        // Priority per cycle is clear, then start, then stop, then counting.
        always_ff @(posedge clk) begin
            if (!rst) begin
                state  <= IDLE;
                cnt    <= '0;
                reload <= '0;
                mode_q <= 1'b0;
                done_q <= 1'b0;
            end else begin
                done_q <= 1'b0;
                if (clear[i]) begin
                    state <= IDLE;
                    cnt   <= '0;
                end else if (start[i] && (ld != '0)) begin
                    cnt    <= ld;
                    reload <= ld;
                    mode_q <= mode[i];
                    state  <= RUN;
                end else if ((state == RUN) && !stop[i] && tick) begin
                    if (cnt != W'(1)) begin
                        cnt <= cnt - W'(1);
                    end else begin
                        done_q <= 1'b1;
                        if (mode_q) begin
                            cnt <= reload;
                        end else begin
                            cnt   <= '0;
                            state <= DONE;
                        end
                    end
                end
            end
        end

        assign busy[i]             = (state == RUN);
        assign expired[i]          = (state == DONE);
        assign done[i]             = done_q;
        assign cnt_out[i*W +: W]   = cnt;
    end

endmodule

// File: tb/tb_multi_timer.sv
// Bench for multi_timer: directed scenarios plus random traffic on two instances
// (PRESCALE 1 and 5), checked every cycle against a rule-level reference model.
module tb_multi_timer;

    localparam int CH = 4;
    localparam int W  = 32;
    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_DONE = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [CH-1:0]   start_a, stop_a, clear_a, mode_a, busy_a, done_a, expired_a;
    logic [CH*W-1:0] load_a, cnt_a;
    logic [CH-1:0]   start_b, stop_b, clear_b, mode_b, busy_b, done_b, expired_b;
    logic [CH*W-1:0] load_b, cnt_b;

    multi_timer #(.CH(CH), .W(W), .PRESCALE(1)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .stop(stop_a), .clear(clear_a),
        .mode(mode_a), .load_val(load_a), .busy(busy_a), .done(done_a),
        .expired(expired_a), .cnt_out(cnt_a)
    );

    multi_timer #(.CH(CH), .W(W), .PRESCALE(5)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .stop(stop_b), .clear(clear_b),
        .mode(mode_b), .load_val(load_b), .busy(busy_b), .done(done_b),
        .expired(expired_b), .cnt_out(cnt_b)
    );

    // Reference model: per channel phase, remaining count, reload and mode.
    int           m_ph   [2][CH];
    logic [W-1:0] m_cnt  [2][CH];
    logic [W-1:0] m_rel  [2][CH];
    bit           m_per  [2][CH];
    bit           m_done [2][CH];
    int           m_edges[2];
    int           m_pre  [2] = '{1, 5};

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_edge(input int d, input logic [CH-1:0] st, input logic [CH-1:0] sp,
                              input logic [CH-1:0] cl, input logic [CH-1:0] md,
                              input logic [CH*W-1:0] ld);
        bit           tk;
        logic [W-1:0] lv;
        if (!rst) begin
            m_edges[d] = 0;
            for (int c = 0; c < CH; c++) begin
                m_ph[d][c] = S_IDLE; m_cnt[d][c] = '0; m_rel[d][c] = '0;
                m_per[d][c] = 0; m_done[d][c] = 0;
            end
            return;
        end
        // Tick happens on every PRESCALE-th edge since the last reset.
        tk = ((m_edges[d] % m_pre[d]) == m_pre[d] - 1);
        m_edges[d]++;
        for (int c = 0; c < CH; c++) begin
            lv = ld[c*W +: W];
            m_done[d][c] = 0;
            if (cl[c]) begin
                m_ph[d][c] = S_IDLE; m_cnt[d][c] = '0;
            end else if (st[c] && lv != 0) begin
                m_cnt[d][c] = lv; m_rel[d][c] = lv; m_per[d][c] = md[c]; m_ph[d][c] = S_RUN;
            end else if (m_ph[d][c] == S_RUN && !sp[c] && tk) begin
                if (m_cnt[d][c] == 1) begin
                    m_done[d][c] = 1;
                    if (m_per[d][c]) m_cnt[d][c] = m_rel[d][c];
                    else begin m_cnt[d][c] = '0; m_ph[d][c] = S_DONE; end
                end else begin
                    m_cnt[d][c] = m_cnt[d][c] - 1;
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < CH; c++) begin
                logic [W-1:0] oc;
                logic ob, od, oe;
                oc = (d == 0) ? cnt_a[c*W +: W] : cnt_b[c*W +: W];
                ob = (d == 0) ? busy_a[c] : busy_b[c];
                od = (d == 0) ? done_a[c] : done_b[c];
                oe = (d == 0) ? expired_a[c] : expired_b[c];
                check($sformatf("d%0d.ch%0d.busy", d, c), 64'(ob), 64'(m_ph[d][c] == S_RUN));
                check($sformatf("d%0d.ch%0d.done", d, c), 64'(od), 64'(m_done[d][c]));
                check($sformatf("d%0d.ch%0d.expired", d, c), 64'(oe), 64'(m_ph[d][c] == S_DONE));
                check($sformatf("d%0d.ch%0d.cnt", d, c), 64'(oc), 64'(m_cnt[d][c]));
            end
        end
    endtask

    task automatic step();
        model_edge(0, start_a, stop_a, clear_a, mode_a, load_a);
        model_edge(1, start_b, stop_b, clear_b, mode_b, load_b);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        start_a = '0; stop_a = '0; clear_a = '0; mode_a = '0; load_a = '0;
        start_b = '0; stop_b = '0; clear_b = '0; mode_b = '0; load_b = '0;
    endtask

    task automatic clear_all();
        clear_a = '1; clear_b = '1;
        step();
        clear_a = '0; clear_b = '0;
    endtask

    task automatic wait_done(input int d, input int c, input int budget, output int n);
        n = budget + 1;
        for (int k = 1; k <= budget; k++) begin
            step();
            if ((d == 0) ? done_a[c] : done_b[c]) begin
                n = k;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int n;
        int pulses;
        rst = 1'b0;
        idle_inputs();
        start_a = '1; load_a = {CH{32'd9}};
        step();
        step();
        check("rst.busy", 64'(busy_a), 64'd0);
        check("rst.cnt", 64'(cnt_a[W-1:0]), 64'd0);
        start_a = '0; load_a = '0;
        rst = 1'b1;
        step();

        // T1: one-shot load 3 on ch0
        load_a[0*W +: W] = 3; start_a[0] = 1'b1;
        step();
        start_a[0] = 1'b0;
        check("t1.cnt3", 64'(cnt_a[0*W +: W]), 64'd3);
        check("t1.busy", 64'(busy_a[0]), 64'd1);
        step(); check("t1.cnt2", 64'(cnt_a[0*W +: W]), 64'd2);
        step(); check("t1.cnt1", 64'(cnt_a[0*W +: W]), 64'd1);
        check("t1.nodone", 64'(done_a[0]), 64'd0);
        step();
        check("t1.cnt0", 64'(cnt_a[0*W +: W]), 64'd0);
        check("t1.done", 64'(done_a[0]), 64'd1);
        check("t1.expired", 64'(expired_a[0]), 64'd1);
        check("t1.idlebusy", 64'(busy_a[0]), 64'd0);
        step(); check("t1.donepulse", 64'(done_a[0]), 64'd0);
        clear_all();

        // T2: periodic load 4 on ch1
        load_a[1*W +: W] = 4; mode_a[1] = 1'b1; start_a[1] = 1'b1;
        step();
        start_a[1] = 1'b0; mode_a[1] = 1'b0;
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (done_a[1]) pulses++;
        end
        check("t2.pulses", 64'(pulses), 64'd3);
        check("t2.busy", 64'(busy_a[1]), 64'd1);
        clear_all();

        // T3: pause for 5 cycles at cnt 6
        load_a[0*W +: W] = 10; start_a[0] = 1'b1;
        step();
        start_a[0] = 1'b0;
        repeat (4) step();
        check("t3.cnt6", 64'(cnt_a[0*W +: W]), 64'd6);
        stop_a[0] = 1'b1;
        repeat (5) step();
        check("t3.hold", 64'(cnt_a[0*W +: W]), 64'd6);
        stop_a[0] = 1'b0;
        wait_done(0, 0, 20, n);
        check("t3.latency", 64'(9 + n), 64'd15);
        clear_all();

        // T4: clear beats start; restart without done; zero load ignored
        load_a[2*W +: W] = 5; start_a[2] = 1'b1; clear_a[2] = 1'b1;
        step();
        clear_a[2] = 1'b0;
        check("t4.clearwins", 64'(busy_a[2]), 64'd0);
        step();
        start_a[2] = 1'b0;
        repeat (3) step();
        check("t4.cnt2", 64'(cnt_a[2*W +: W]), 64'd2);
        load_a[2*W +: W] = 7; start_a[2] = 1'b1;
        step();
        start_a[2] = 1'b0;
        check("t4.restart", 64'(cnt_a[2*W +: W]), 64'd7);
        check("t4.nodone", 64'(done_a[2]), 64'd0);
        load_a[2*W +: W] = 0; start_a[2] = 1'b1;
        step();
        start_a[2] = 1'b0;
        check("t4.zeroload", 64'(cnt_a[2*W +: W]), 64'd6);
        clear_all();

        // T6: simultaneous expiry, then reset mid-count
        load_a = {CH{32'd5}}; start_a = '1;
        step();
        start_a = '0;
        repeat (4) step();
        step();
        check("t6.alldone", 64'(done_a), 64'hF);
        start_a = '1;
        step();
        start_a = '0;
        step();
        rst = 1'b0;
        step();
        check("t6.rstbusy", 64'(busy_a), 64'd0);
        check("t6.rstcnt", 64'(cnt_a), 64'd0);
        rst = 1'b1;
        load_a = '0;

        // T5: prescale 5, load 2, every prescaler phase
        for (int ph = 0; ph < 5; ph++) begin
            repeat (ph + 1) step();
            load_b[0*W +: W] = 2; start_b[0] = 1'b1;
            step();
            start_b[0] = 1'b0;
            wait_done(1, 0, 15, n);
            check($sformatf("t5.ph%0d.lo", ph), 64'(n >= 6), 64'd1);
            check($sformatf("t5.ph%0d.hi", ph), 64'(n <= 10), 64'd1);
        end
        clear_all();

        // Random traffic on both instances
        for (int k = 0; k < 600; k++) begin
            rst = ($urandom_range(99) != 0);
            for (int c = 0; c < CH; c++) begin
                start_a[c] = ($urandom_range(7) == 0);
                stop_a[c]  = ($urandom_range(5) == 0);
                clear_a[c] = ($urandom_range(29) == 0);
                mode_a[c]  = 1'($urandom_range(1));
                load_a[c*W +: W] = W'($urandom_range(12));
                start_b[c] = ($urandom_range(7) == 0);
                stop_b[c]  = ($urandom_range(5) == 0);
                clear_b[c] = ($urandom_range(29) == 0);
                mode_b[c]  = 1'($urandom_range(1));
                load_b[c*W +: W] = W'($urandom_range(6));
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
